// File: rtl/sim_status_pkg.sv
// Shared types and constants for the status writer: frame geometry, serializer states, FIFO entry layout.
package sim_status_pkg;

    localparam int         FRAME_BYTES      = 5;
    localparam logic [7:0] EXIT_TAG_DEFAULT = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_D0,
        ST_D1,
        ST_D2,
        ST_D3
    } state_e;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/status_fifo.sv
// Synchronous FIFO holding queued status entries; occupancy counter is kept separately from the pointers.
module status_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == CNT_FULL);
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until the counter says it was written.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/sim_status_writer.sv
// Queues tagged status words and streams each as a 5-byte frame (tag, then data LSB first);
// latches the first EXIT_TAG payload as a sticky exit code once its frame has drained.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | no frame loaded; pops the FIFO head when one exists
// HDR     | presenting the tag byte
// D0..D2  | presenting data bytes 0..2
// D3      | presenting data byte 3 (last); chains into next frame
module sim_status_writer
    import sim_status_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] EXIT_TAG = EXIT_TAG_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_tag,
    input  logic [31:0]            in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_byte,
    output logic                   out_last,
    output logic                   exit_valid,
    output logic [31:0]            exit_code,
    output logic [$clog2(DEPTH):0] count
);
    state_e state_q, state_d;
    entry_t cur_q, cur_d;
    logic   exit_valid_q, exit_valid_d;
    logic [31:0] exit_code_q, exit_code_d;

    entry_t head;
    logic   fifo_full, fifo_empty, fifo_push, fifo_pop, out_hs;

    assign in_ready  = !fifo_full && !exit_valid_q;
    assign fifo_push = in_valid && in_ready;

    status_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_BYTES * 8)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_data ({in_tag, in_data}),
        .pop     (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        exit_valid_d = exit_valid_q;
        exit_code_d  = exit_code_q;
        fifo_pop     = 1'b0;
        out_valid    = (state_q != ST_IDLE);
        out_last     = (state_q == ST_D3);
        out_hs       = out_valid && out_ready;
        out_byte     = 8'h00;

        case (state_q)
            ST_HDR: out_byte = cur_q.tag;
            ST_D0:  out_byte = cur_q.data[7:0];
            ST_D1:  out_byte = cur_q.data[15:8];
            ST_D2:  out_byte = cur_q.data[23:16];
            ST_D3:  out_byte = cur_q.data[31:24];
            default: out_byte = 8'h00;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = head;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: if (out_hs) state_d = ST_D0;
            ST_D0:  if (out_hs) state_d = ST_D1;
            ST_D1:  if (out_hs) state_d = ST_D2;
            ST_D2:  if (out_hs) state_d = ST_D3;
            ST_D3: begin
                if (out_hs) begin
                    // First exit wins; later exit frames still stream but do not overwrite.
                    if (cur_q.tag == EXIT_TAG && !exit_valid_q) begin
                        exit_valid_d = 1'b1;
                        exit_code_d  = cur_q.data;
                    end
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        cur_d    = head;
                        state_d  = ST_HDR;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
        end
    end

    assign exit_valid = exit_valid_q;
    assign exit_code  = exit_code_q;

endmodule

// File: tb/tb_sim_status_writer.sv
// Bench for sim_status_writer: byte-stream scoreboard plus exit model, with directed scenarios.
module tb_sim_status_writer;
    import sim_status_pkg::*;

    localparam int         DEPTH    = 4;
    localparam logic [7:0] EXIT_TAG = 8'hFF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_tag = 8'h00;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        exit_valid;
    logic [31:0] exit_code;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sim_status_writer #(
        .DEPTH    (DEPTH),
        .EXIT_TAG (EXIT_TAG)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tag     (in_tag),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .exit_valid (exit_valid),
        .exit_code  (exit_code),
        .count      (count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  b;
        logic        last;
        logic [7:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [8:0]  log_q[$];
    exp_t        e_cur;
    logic [7:0]  mb;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_byte = 8'h00;
    logic        prev_last = 1'b0;
    logic        mdl_exit = 1'b0;
    logic        mdl_pend = 1'b0;
    logic [31:0] mdl_code = 32'h0;
    int          exit_hs_cyc = -1;
    int          exit_rise_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: every accepted word becomes tag then data LSB-first on the stream, in accept order.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
            mdl_exit   = 1'b0;
            mdl_pend   = 1'b0;
        end else begin
            if (mdl_pend) begin
                mdl_exit = 1'b1;
                mdl_pend = 1'b0;
            end
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_byte", out_byte, prev_byte);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got=%h want=none (t=%0t)", out_byte, $time);
                end else begin
                    e_cur = exp_q.pop_front();
                    check("stream_byte", out_byte, e_cur.b);
                    check("stream_last", out_last, e_cur.last);
                    if (e_cur.last && e_cur.tag == EXIT_TAG && !mdl_exit && !mdl_pend) begin
                        mdl_pend    = 1'b1;
                        mdl_code    = e_cur.data;
                        exit_hs_cyc = cyc;
                    end
                end
                log_q.push_back({out_last, out_byte});
            end
            check("exit_valid", exit_valid, mdl_exit);
            if (mdl_exit) begin
                check("exit_code", exit_code, mdl_code);
                check("in_ready_after_exit", in_ready, 0);
            end
            if (exit_valid && exit_rise_cyc < 0) exit_rise_cyc = cyc;
            if (in_valid && in_ready) begin
                for (int i = 0; i < FRAME_BYTES; i++) begin
                    if (i == 0) mb = in_tag;
                    else        mb = in_data[8*(i-1) +: 8];
                    exp_q.push_back('{b: mb, last: (i == FRAME_BYTES - 1), tag: in_tag, data: in_data});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_byte  = out_byte;
            prev_last  = out_last;
        end
    end

    task automatic push(input logic [7:0] t, input logic [31:0] d, input int budget, output bit ok);
        ok = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b1;
        in_tag   = t;
        in_data  = d;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (!out_valid && count == 3'd0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: timeout still busy count=%0d want drained", nm, count);
        end
        #1;
    endtask

    task automatic check_frame(input int base, input logic [7:0] t, input logic [31:0] d, input string nm);
        logic [7:0] bb;
        if (log_q.size() < base + 5) begin
            total++;
            bad++;
            $display("FAIL %s_len: got=%0d want>=%0d", nm, log_q.size(), base + 5);
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (i == 0) bb = t;
                else        bb = d[8*(i-1) +: 8];
                check(nm, {23'b0, log_q[base+i]}, {23'b0, (i == 4), bb});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int acc, base, run;
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_byte", out_byte, 0);
        check("rst_out_last", out_last, 0);
        check("rst_exit_valid", exit_valid, 0);
        check("rst_exit_code", exit_code, 0);
        check("rst_count", count, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Single word: latency and byte order
        out_ready = 1'b1;
        base = log_q.size();
        push(8'h01, 32'hDEADBEEF, 10, ok);
        check("t1_accept", ok, 1);
        @(negedge clock);
        check("t1_lat_pop_cycle", out_valid, 0);
        @(negedge clock);
        check("t1_lat_hdr_valid", out_valid, 1);
        check("t1_lat_hdr_byte", out_byte, 8'h01);
        wait_idle(50, "t1_drain");
        check_frame(base, 8'h01, 32'hDEADBEEF, "t1_frame");
        check("t1_last_byte", {23'b0, log_q[base+4]}, 32'h1DE);
        check("t1_count", count, 0);

        // Backpressure pattern 1,0,0,1
        out_ready = 1'b0;
        base = log_q.size();
        push(8'h02, 32'h11223344, 10, ok);
        check("t2_accept", ok, 1);
        for (int i = 0; i < 60 && log_q.size() < base + 5; i++) begin
            out_ready = pat[i % 4];
            @(posedge clock); #1;
        end
        out_ready = 1'b0;
        @(negedge clock); #1;
        check("t2_len", log_q.size(), base + 5);
        check_frame(base, 8'h02, 32'h11223344, "t2_frame");

        // Fill: one word sits in the serializer, four in the FIFO
        base = log_q.size();
        acc  = 0;
        for (int k = 0; k < 6; k++) begin
            push(8'h10 + 8'(k), 32'hA0A0_0000 + k, 4, ok);
            if (ok) acc++;
        end
        check("t3_accepted", acc, 5);
        check("t3_count_full", count, 4);
        check("t3_in_ready_full", in_ready, 0);
        out_ready = 1'b1;
        run = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (out_valid) run++;
            else if (run > 0) break;
        end
        check("t3_no_bubble_run", run, 25);
        wait_idle(50, "t3_drain");
        check_frame(base, 8'h10, 32'hA0A00000, "t3_frame_first");
        check_frame(base + 20, 8'h14, 32'hA0A00004, "t3_frame_last");

        // Simultaneous push and pop at count 2, then reset mid-frame
        out_ready = 1'b0;
        push(8'h20, 32'h20202020, 10, ok);
        push(8'h21, 32'h2B2A2928, 10, ok);
        push(8'h22, 32'h22222222, 10, ok);
        @(negedge clock);
        check("t5_count_pre", count, 2);
        @(posedge clock); #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_tag   = 8'h23;
        in_data  = 32'h23232323;
        @(negedge clock);
        check("t5_d3_align", out_last, 1);
        check("t5_push_ready", in_ready, 1);
        check("t5_count_before", count, 2);
        @(posedge clock); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        check("t5_count_simul", count, 2);
        @(posedge clock); #1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        @(negedge clock);
        check("t5_d1_byte", out_byte, 8'h29);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_out_byte", out_byte, 0);
        check("t5_rst_out_last", out_last, 0);
        check("t5_rst_in_ready", in_ready, 1);
        check("t5_rst_count", count, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        base = log_q.size();
        push(8'h30, 32'h33323130, 10, ok);
        check("t5_post_accept", ok, 1);
        wait_idle(50, "t5_drain");
        check("t5_post_len", log_q.size(), base + 5);
        check_frame(base, 8'h30, 32'h33323130, "t5_post_frame");

        // Exit: first exit wins, queued words still drain
        out_ready = 1'b0;
        base = log_q.size();
        push(8'h03, 32'h00000000, 10, ok);
        push(EXIT_TAG, 32'h0000002A, 10, ok);
        push(8'h04, 32'h00000005, 10, ok);
        push(EXIT_TAG, 32'h00000099, 10, ok);
        check("t4_count_queued", count, 3);
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (exit_valid) break;
        end
        check("t4_exit_seen", exit_valid, 1);
        wait_idle(100, "t4_drain");
        check("t4_exit_code", exit_code, 32'h2A);
        check("t4_exit_latency", exit_rise_cyc - exit_hs_cyc, 1);
        check("t4_in_ready", in_ready, 0);
        check("t4_len", log_q.size(), base + 20);
        check_frame(base + 10, 8'h04, 32'h00000005, "t4_frame_third");
        check_frame(base + 15, EXIT_TAG, 32'h00000099, "t4_frame_fourth");
        push(8'h05, 32'h55555555, 3, ok);
        check("t4_push_blocked", ok, 0);
        check("t4_exit_code_final", exit_code, 32'h2A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
